fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output reorder stage after the radix-2 butterfly PE of the 16-point FFT. It captures the 8 result pairs the PE produces on the final stage (bit-reversed order) into one of two ping-pong banks. It then streams the 16 complex results in natural order (X0..X15) over a valid/ready interface. One bank fills while the other drains, so the PE never stalls.

## Interface
- DATA_WIDTH, 32: packed complex word; [31:16] real, [15:0] imaginary, both signed two's complement.
- N_PAIRS, 8: pairs per frame; frame length is 2*N_PAIRS = 16. Must be a power of two.

- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  PE result pair valid (driven by PE fft_pe_valid); no back-pressure toward PE.
- in_a  in  DATA_WIDTH  butterfly upper output of pair k.
- in_b  in  DATA_WIDTH  butterfly lower (twiddled) output of pair k.
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  consumer accepts; handshake = out_valid & out_ready.
- out_data  out  DATA_WIDTH  result word, unmodified from capture.
- out_index  out  4  natural frequency index of out_data (0..15).
- out_last  out  1  high with index 15.
- overflow  out  1  sticky: a pair arrived with no free bank; cleared only by rst.

## Operation
- Each bank has 16 words, a state (FREE, FILL, DRAIN) and a 3-bit write pair counter k.
- Capture: on in_valid, the write bank stores in_a at index bitrev3(k) and in_b at index bitrev3(k)+8. k increments and wraps at N_PAIRS-1.
- Write bank FREE on first pair -> FILL. When k==7 is captured -> DRAIN, queued behind any bank already draining. wr_bank then toggles.
- Drain: rd_bank outputs indices 0..15 in order, one per handshake. After the handshake with index 15 the bank goes to FREE and rd_bank toggles. Banks drain strictly in fill order.
- out_data and out_index come combinationally from rd_bank's array and read pointer. out_valid is a registered state bit.
- Overflow: in_valid while wr_bank is DRAIN -> pair dropped, no state change, overflow set.
  - Exception: if the index-15 handshake on that bank occurs in the same cycle, the pair is accepted into the freed bank as k=0.
- Data passes through with no arithmetic, rounding or sign change.

## Timing
- Reset values: out_valid 0, out_last 0, out_index 0, out_data 0, overflow 0. Both banks FREE, wr_bank=rd_bank=0, all counters 0.
- Latency: 8th pair sampled at edge E -> out_valid=1, out_index=0 in the cycle after E, provided the other bank is not draining.
- Throughput: 1 word/cycle with out_ready held high. PE pairs arrive at most every 2 cycles, so a 16-cycle drain never overflows when ready is continuous.
- out_valid stays high with out_data/out_index stable while out_ready=0.
- Back-to-back frames: if the second bank is already DRAIN-queued when the first finishes, index 0 of the second frame is valid in the cycle right after the first frame's index-15 handshake.
- rst mid-frame or mid-drain: all outputs and banks return to reset values immediately (async). Partial frames are discarded.

## Structure
- Shared FFT package: bank state enum (FREE/FILL/DRAIN), the FRAME_LEN=16 constant, and a bitrev3 function reused by the upstream input dispatcher.
- One sub-module, fft_reorder_bank: 16-word register array, write counter and state. Instantiated twice. Top level holds wr/rd bank selection, read pointer, handshake and overflow.

## Test plan
- Single frame, out_ready=1: pairs k=0..7 with in_a=0x0000_0100+k, in_b=0x0000_0200+k, every 2 cycles.
  - out sequence: index0=0x100, index8=0x200, index4=0x101, index12=0x201, ... index15=0x207.
  - out_valid first rises 1 cycle after the 8th pair; out_last on index 15.
- Back-pressure: same frame, out_ready toggled 1-0-1 -> each word held stable while ready=0; 16 handshakes exactly; no duplicates or drops.
- Ping-pong: two frames back-to-back (frame B real parts negated, e.g. 0xFFFF_0000) -> B fills during A's drain; B index 0 follows A index 15 with no gap; overflow stays 0.
- Overflow: out_ready=0, send 3 frames -> the third frame's pairs are dropped and overflow=1. Release ready -> frames 1 and 2 drain intact; overflow stays 1.
- Simultaneous free/write: hold ready so the index-15 handshake coincides with in_valid to that bank -> pair accepted as k=0; overflow stays 0.
- Reset mid-drain: assert rst at index 5 -> out_valid=0 immediately. A new frame after release drains from index 0 with correct data.

Source files
------------

// File: rtl/fft_out_reorder_pkg.sv
// rtl/fft_out_reorder_pkg.sv - shared FFT types, frame constants and bit-reverse helper
package fft_out_reorder_pkg;

  localparam int FRAME_LEN = 16;
  localparam int HALF_LEN  = FRAME_LEN / 2;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_DRAIN = 2'd2
  } bank_state_e;

  // Reverse a 3-bit pair index; also used by the upstream input dispatcher.
  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_out_reorder_bank.sv
// rtl/fft_out_reorder_bank.sv - one ping-pong bank: 16-word store, pair counter, fill/drain state
module fft_reorder_bank
  import fft_out_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_a,
  input  logic [DATA_WIDTH-1:0] wr_b,
  input  logic                  drain_done,
  input  logic [3:0]            rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  output bank_state_e           state,
  output bank_state_e           state_next,
  output logic [2:0]            wr_k
);

  logic [DATA_WIDTH-1:0] mem_q [FRAME_LEN];
  logic [DATA_WIDTH-1:0] mem_d [FRAME_LEN];
  bank_state_e           state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [2:0]            k_eff;
  logic [2:0]            slot;

  // A finishing drain frees the bank first, so a pair in the same cycle lands as k=0.
  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    k_d     = k_q;
    k_eff   = k_q;
    slot    = '0;
    if (drain_done) begin
      state_d = BANK_FREE;
      k_eff   = '0;
      k_d     = '0;
    end
    if (wr_en) begin
      slot                 = bitrev3(k_eff);
      mem_d[{1'b0, slot}]  = wr_a;
      mem_d[{1'b1, slot}]  = wr_b;
      if (k_eff == 3'(HALF_LEN - 1)) begin
        state_d = BANK_DRAIN;
        k_d     = '0;
      end else begin
        state_d = BANK_FILL;
        k_d     = k_eff + 3'd1;
      end
    end
  end

  // Bank storage, state and pair counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) mem_q[i] <= '0;
      state_q <= BANK_FREE;
      k_q     <= '0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  assign rd_data    = mem_q[rd_index];
  assign state      = state_q;
  assign state_next = state_d;
  assign wr_k       = k_q;

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong bit-reversed to natural-order FFT output stage
module fft_out_reorder
  import fft_out_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_PAIRS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            out_index,
  output logic                  out_last,
  output logic                  overflow
);

  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [3:0]            rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;

  bank_state_e           bank_state [2];
  bank_state_e           bank_next  [2];
  logic [2:0]            bank_k     [2];
  logic [DATA_WIDTH-1:0] bank_data  [2];
  logic                  bank_wr    [2];
  logic                  bank_done  [2];

  logic                  hs;
  logic                  frame_done;
  logic                  accept;

  fft_reorder_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
    .clk(clk), .rst(rst), .wr_en(bank_wr[0]), .wr_a(in_a), .wr_b(in_b),
    .drain_done(bank_done[0]), .rd_index(rd_ptr_q), .rd_data(bank_data[0]),
    .state(bank_state[0]), .state_next(bank_next[0]), .wr_k(bank_k[0])
  );

  fft_reorder_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
    .clk(clk), .rst(rst), .wr_en(bank_wr[1]), .wr_a(in_a), .wr_b(in_b),
    .drain_done(bank_done[1]), .rd_index(rd_ptr_q), .rd_data(bank_data[1]),
    .state(bank_state[1]), .state_next(bank_next[1]), .wr_k(bank_k[1])
  );

  // Handshake detection and steering of captures/frees to the selected banks.
  always_comb begin
    hs           = out_valid_q & out_ready;
    frame_done   = hs && (rd_ptr_q == 4'(FRAME_LEN - 1));
    accept       = in_valid && ((bank_state[wr_bank_q] != BANK_DRAIN) ||
                                (frame_done && (rd_bank_q == wr_bank_q)));
    bank_wr[0]   = accept && !wr_bank_q;
    bank_wr[1]   = accept && wr_bank_q;
    bank_done[0] = frame_done && !rd_bank_q;
    bank_done[1] = frame_done && rd_bank_q;
  end

  // Next values for bank selection, read pointer, valid and sticky overflow.
  always_comb begin
    wr_bank_d   = wr_bank_q ^ (accept && (bank_k[wr_bank_q] == 3'(N_PAIRS - 1)));
    rd_bank_d   = rd_bank_q ^ frame_done;
    rd_ptr_d    = hs ? rd_ptr_q + 4'd1 : rd_ptr_q;
    out_valid_d = (bank_next[rd_bank_d] == BANK_DRAIN);
    overflow_d  = overflow_q | (in_valid & ~accept);
  end

  // Top-level control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = bank_data[rd_bank_q];
  assign out_index = rd_ptr_q;
  assign out_last  = out_valid_q && (rd_ptr_q == 4'(FRAME_LEN - 1));
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - self-checking bench for fft_out_reorder
module tb_fft_out_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        out_last;
  logic        overflow;

  fft_out_reorder #(.DATA_WIDTH(32), .N_PAIRS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a flat queue of completed frames in natural order plus one partial frame.
  logic [31:0] exp_q[$];
  logic [31:0] part[16];
  int          part_k;
  int          rd_idx;
  logic        m_ovf;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } cap_t;
  cap_t cap_q[$];
  int   cyc = 0;

  typedef struct {
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int brev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    part_k = 0;
    rd_idx = 0;
    m_ovf  = 1'b0;
    for (int i = 0; i < 16; i++) part[i] = '0;
  endtask

  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b, input logic rdy);
    bit mv;
    int held;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    mv = (exp_q.size() > 0);
    chk("out_valid", out_valid, mv);
    chk("overflow", overflow, m_ovf);
    if (mv) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_index", out_index, rd_idx);
      chk("out_last", out_last, rd_idx == 15);
    end
    if (out_valid && rdy) cap_q.push_back('{out_index, out_data, out_last, cyc});
    @(posedge clk);
    if (mv && rdy) begin
      void'(exp_q.pop_front());
      rd_idx = (rd_idx + 1) % 16;
    end
    if (iv) begin
      held = (exp_q.size() + 15) / 16;
      if (part_k > 0 || held < 2) begin
        part[brev(part_k)]     = a;
        part[brev(part_k) + 8] = b;
        part_k++;
        if (part_k == 8) begin
          for (int i = 0; i < 16; i++) exp_q.push_back(part[i]);
          part_k = 0;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic send_rand_frame(input int gap, input logic rdy);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, $urandom, $urandom, rdy);
      for (int g = 1; g < gap; g++) cycle(1'b0, '0, '0, rdy);
    end
  endtask

  task automatic drain(input int max, input bit toggle);
    int  n = 0;
    logic r = 1'b1;
    while (exp_q.size() > 0 && n < max) begin
      cycle(1'b0, '0, '0, r);
      if (toggle) r = ~r;
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
    end
  endtask

  task automatic compare_table(input string tag);
    chk({tag, "_count"}, cap_q.size(), 16);
    for (int i = 0; i < 16 && i < cap_q.size(); i++) begin
      chk({tag, "_idx"}, cap_q[i].idx, i);
      chk({tag, "_data"}, cap_q[i].data, tbl[i].exp_data);
      chk({tag, "_last"}, cap_q[i].last, tbl[i].exp_last);
    end
  endtask

  initial begin
    logic [31:0] ed [16];
    logic        tog;
    int          n;
    ed = '{32'h100, 32'h104, 32'h102, 32'h106, 32'h101, 32'h105, 32'h103, 32'h107,
           32'h200, 32'h204, 32'h202, 32'h206, 32'h201, 32'h205, 32'h203, 32'h207};
    for (int i = 0; i < 16; i++) begin
      tbl[i].in_a     = 32'h0000_0100 + 32'(i % 8);
      tbl[i].in_b     = 32'h0000_0200 + 32'(i % 8);
      tbl[i].exp_data = ed[i];
      tbl[i].exp_last = (i == 15);
    end

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    #10 rst = 1'b0;

    // single frame, continuous ready, pairs every 2 cycles
    cap_q.delete();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, tbl[k].in_a, tbl[k].in_b, 1'b1);
      if (k == 7) begin
        chk("latency_valid", out_valid, 1);
        chk("latency_index", out_index, 0);
      end else begin
        cycle(1'b0, '0, '0, 1'b1);
      end
    end
    drain(40, 1'b0);
    compare_table("single");

    // same frame with ready toggling every cycle
    cap_q.delete();
    tog = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, tbl[k].in_a, tbl[k].in_b, tog); tog = ~tog;
      cycle(1'b0, '0, '0, tog); tog = ~tog;
    end
    drain(80, 1'b1);
    compare_table("backpressure");

    // ping-pong: two random frames back to back, B fills while A drains
    cap_q.delete();
    send_rand_frame(2, 1'b1);
    send_rand_frame(2, 1'b1);
    drain(60, 1'b0);
    chk("pingpong_count", cap_q.size(), 32);
    if (cap_q.size() == 32) chk("pingpong_no_gap", cap_q[16].cyc - cap_q[15].cyc, 1);
    chk("pingpong_overflow", overflow, 0);

    // simultaneous free and write: pair arrives with the index-15 handshake
    cap_q.delete();
    send_rand_frame(1, 1'b0);
    send_rand_frame(1, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 32'hA5A5_0000, 32'h5A5A_0000, 1'b1);
    chk("simul_overflow", overflow, 0);
    for (int k = 1; k < 8; k++) cycle(1'b1, $urandom, $urandom, 1'b1);
    drain(60, 1'b0);
    chk("simul_count", cap_q.size(), 48);
    if (cap_q.size() == 48) begin
      chk("simul_k0_a", cap_q[32].data, 32'hA5A5_0000);
      chk("simul_k0_b", cap_q[40].data, 32'h5A5A_0000);
    end

    // overflow: three frames with ready low, third dropped
    cap_q.delete();
    send_rand_frame(1, 1'b0);
    send_rand_frame(1, 1'b0);
    send_rand_frame(1, 1'b0);
    chk("ovf_set", overflow, 1);
    drain(60, 1'b0);
    chk("ovf_count", cap_q.size(), 32);
    chk("ovf_sticky", overflow, 1);

    // reset in the middle of a drain
    send_rand_frame(2, 1'b1);
    n = 0;
    while (rd_idx != 5 && n < 40) begin
      cycle(1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("pre_rst_index", out_index, 5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_index", out_index, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_overflow", overflow, 0);
    rst = 1'b0;
    model_reset();
    cap_q.delete();
    send_rand_frame(2, 1'b1);
    drain(40, 1'b0);
    chk("post_rst_count", cap_q.size(), 16);
    if (cap_q.size() > 0) chk("post_rst_first_idx", cap_q[0].idx, 0);

    // random soak against the model
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 2) == 0, $urandom, $urandom, $urandom_range(0, 3) != 0);
    drain(80, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
